// File: rtl/gamepad_pkg.sv
// Shared constants for the gamepad shift receiver: default frame width and
// the bit position of each button within a received frame.
package gamepad_pkg;

  localparam int NBITS_DEFAULT = 12;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit; both flops
// clear to 0 under synchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gamepad_shift_receiver.sv
// Receives latch/clock/data frames from a gamepad Pmod, validates them and
// publishes the last accepted button state with a presence watchdog.
module gamepad_shift_receiver
  import gamepad_pkg::*;
#(
  parameter int NBITS  = NBITS_DEFAULT,
  parameter int WDOG_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pmod_latch,
  input  logic             pmod_clk,
  input  logic             pmod_data,
  output logic [NBITS-1:0] buttons,
  output logic             up,
  output logic             down,
  output logic             left,
  output logic             right,
  output logic             start,
  output logic             select,
  output logic             is_present,
  output logic             frame_valid
);

  localparam int CNT_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBITS);

  logic latch_s, clk_s, data_s;
  logic latch_d, clk_d, data_d;
  logic latch_fall, clk_rise;
  logic [NBITS-1:0]  shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WDOG_W-1:0] wdog;
  logic              frame_full;
  logic              frame_accept;
  logic              frame_empty;

  sync2 u_sync_latch (.clk(clk), .rst_n(rst_n), .d(pmod_latch), .q(latch_s));
  sync2 u_sync_clk   (.clk(clk), .rst_n(rst_n), .d(pmod_clk),   .q(clk_s));
  sync2 u_sync_data  (.clk(clk), .rst_n(rst_n), .d(pmod_data),  .q(data_s));

  assign frame_full   = latch_fall && (bit_cnt == CNT_FULL);
  assign frame_accept = frame_full && (shreg != '1);
  assign frame_empty  = frame_full && (shreg == '1);

  // Edge pulses are registered, which puts the button update exactly four
  // clocks after the pin edge; data_d keeps the sampled bit aligned with them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch_d     <= 1'b0;
      clk_d       <= 1'b0;
      data_d      <= 1'b0;
      latch_fall  <= 1'b0;
      clk_rise    <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      wdog        <= '0;
      buttons     <= '0;
      is_present  <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      latch_d     <= latch_s;
      clk_d       <= clk_s;
      data_d      <= data_s;
      latch_fall  <= latch_d & ~latch_s;
      clk_rise    <= clk_s & ~clk_d;
      frame_valid <= 1'b0;

      if (wdog != '1) begin
        wdog <= wdog + 1'b1;
      end else begin
        buttons    <= '0;
        is_present <= 1'b0;
      end

      // A latch edge wins over a coincident bit clock, so that bit is dropped.
      if (latch_fall) begin
        bit_cnt <= '0;
        if (frame_accept) begin
          buttons     <= shreg;
          is_present  <= 1'b1;
          frame_valid <= 1'b1;
          wdog        <= '0;
        end else if (frame_empty) begin
          buttons    <= '0;
          is_present <= 1'b0;
        end
      end else if (clk_rise) begin
        shreg <= {data_d, shreg[NBITS-1:1]};
        if (bit_cnt != CNT_FULL) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign up     = buttons[BTN_UP];
  assign down   = buttons[BTN_DOWN];
  assign left   = buttons[BTN_LEFT];
  assign right  = buttons[BTN_RIGHT];
  assign start  = buttons[BTN_START];
  assign select = buttons[BTN_SELECT];

endmodule

// File: tb/tb_gamepad_shift_receiver.sv
// Directed self-checking bench for gamepad_shift_receiver, run with an 8-bit
// watchdog so the presence timeout can be reached quickly.
module tb_gamepad_shift_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pmod_latch = 1'b0;
  logic        pmod_clk = 1'b0;
  logic        pmod_data = 1'b0;
  logic [11:0] buttons;
  logic        up, down, left, right, start, select;
  logic        is_present, frame_valid;

  int n_compared = 0;
  int n_mismatched = 0;
  int fv_count = 0;
  int fv_before;
  logic [5:0]  fv_hist;
  logic [11:0] btn_before_edge;

  gamepad_shift_receiver #(.NBITS(12), .WDOG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pmod_latch(pmod_latch), .pmod_clk(pmod_clk), .pmod_data(pmod_data),
    .buttons(buttons),
    .up(up), .down(down), .left(left), .right(right),
    .start(start), .select(select),
    .is_present(is_present), .frame_valid(frame_valid)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_count++;
  end

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task applyReset();
    rst_n = 1'b0;
    pmod_latch = 1'b0;
    pmod_clk = 1'b0;
    pmod_data = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(2);
  endtask

  task sendBit(input logic b);
    pmod_data = b;
    waitCycles(3);
    pmod_clk = 1'b1;
    waitCycles(3);
    pmod_clk = 1'b0;
  endtask

  // Opens a frame with a latch pulse, clocks n bits of v (bit 0 first) and
  // leaves the latch high so the caller controls the closing edge.
  task applyStimulus(input logic [11:0] v, input int n);
    pmod_latch = 1'b1;
    waitCycles(6);
    pmod_latch = 1'b0;
    waitCycles(6);
    for (int i = 0; i < n; i++) sendBit(v[i]);
    pmod_latch = 1'b1;
    waitCycles(6);
  endtask

  task dropLatch();
    pmod_latch = 1'b0;
    waitCycles(6);
  endtask

  task dropLatchWatch();
    pmod_latch = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      waitCycles(1);
      fv_hist[k-1] = frame_valid;
      if (k == 3) btn_before_edge = buttons;
    end
  endtask

  // Bit clock rises in the same cycle the latch falls.
  task coincidentClose(input logic b);
    pmod_data = b;
    waitCycles(3);
    pmod_clk = 1'b1;
    pmod_latch = 1'b0;
    waitCycles(6);
    pmod_clk = 1'b0;
    waitCycles(2);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    applyReset();
    checkOutput("reset_buttons", buttons, 12'h000);
    checkOutput("reset_present", is_present, 1'b0);
    checkOutput("reset_fv", frame_valid, 1'b0);

    // Single "up" press with latency watch on the closing latch edge
    applyStimulus(12'h010, 12);
    fv_before = fv_count;
    dropLatchWatch();
    checkOutput("up_fv_timing", fv_hist, 6'b001000);
    checkOutput("up_btn_before", btn_before_edge, 12'h000);
    checkOutput("up_buttons", buttons, 12'h010);
    checkOutput("up_decode", {up, down, left, right, start, select}, 6'b100000);
    checkOutput("up_present", is_present, 1'b1);
    checkOutput("up_fv_count", fv_count - fv_before, 1);

    // Short frame is discarded
    fv_before = fv_count;
    applyStimulus(12'h0FF, 7);
    dropLatch();
    checkOutput("short_buttons", buttons, 12'h010);
    checkOutput("short_present", is_present, 1'b1);
    checkOutput("short_fv_count", fv_count - fv_before, 0);

    // Coincident edges with only 11 bits counted: rejected
    fv_before = fv_count;
    applyStimulus(12'h7FE, 11);
    coincidentClose(1'b1);
    checkOutput("coinc11_buttons", buttons, 12'h010);
    checkOutput("coinc11_fv_count", fv_count - fv_before, 0);

    // Coincident edges after 12 bits: accepted, 13th bit not shifted
    fv_before = fv_count;
    applyStimulus(12'h001, 12);
    coincidentClose(1'b1);
    checkOutput("coinc12_buttons", buttons, 12'h001);
    checkOutput("coinc12_present", is_present, 1'b1);
    checkOutput("coinc12_fv_count", fv_count - fv_before, 1);

    // All-ones frame means no controller
    fv_before = fv_count;
    applyStimulus(12'hFFF, 12);
    dropLatch();
    checkOutput("ones_buttons", buttons, 12'h000);
    checkOutput("ones_present", is_present, 1'b0);
    checkOutput("ones_fv_count", fv_count - fv_before, 0);

    // Valid "right" frame then watchdog expiry
    applyStimulus(12'h080, 12);
    dropLatch();
    checkOutput("right_buttons", buttons, 12'h080);
    checkOutput("right_decode", right, 1'b1);
    checkOutput("right_present", is_present, 1'b1);
    waitCycles(240);
    checkOutput("wdog_early_present", is_present, 1'b1);
    checkOutput("wdog_early_buttons", buttons, 12'h080);
    waitCycles(30);
    checkOutput("wdog_present", is_present, 1'b0);
    checkOutput("wdog_buttons", buttons, 12'h000);

    // Reset in the middle of a frame, then a fresh "start" frame
    pmod_latch = 1'b1;
    waitCycles(6);
    pmod_latch = 1'b0;
    waitCycles(6);
    for (int i = 0; i < 6; i++) sendBit(1'b1);
    applyReset();
    checkOutput("midrst_buttons", buttons, 12'h000);
    checkOutput("midrst_present", is_present, 1'b0);
    fv_before = fv_count;
    applyStimulus(12'h008, 12);
    dropLatch();
    checkOutput("start_buttons", buttons, 12'h008);
    checkOutput("start_decode", {up, down, left, right, start, select}, 6'b000010);
    checkOutput("start_present", is_present, 1'b1);
    checkOutput("start_fv_count", fv_count - fv_before, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
